// File: rtl/portas_logicas_pipe.sv
// Two-stage pipelined bitwise gate block with valid/ready handshake and eq/zero flags.
// Build option PORTAS_LOGICAS_ACC_EN adds an accumulator that can replace operand b.
module portas_logicas_pipe #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   op,
   input  logic         acc,
   input  logic         acc_clr,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] y,
   output logic         eq,
   output logic         zero
);

   logic         s1_v_q, s1_v_d;
   logic [W-1:0] s1_a_q, s1_a_d;
   logic [W-1:0] s1_b_q, s1_b_d;
   logic [2:0]   s1_op_q, s1_op_d;
   logic         s2_v_q, s2_v_d;
   logic [W-1:0] y_q, y_d;
   logic         eq_q, eq_d;
   logic         zero_q, zero_d;

   logic         accept;
   logic         advance;
   logic [W-1:0] b_eff;
   logic [W-1:0] y_calc;

   assign advance  = s1_v_q && (!s2_v_q || out_ready);
   assign in_ready = !s1_v_q || advance;
   assign accept   = in_valid && in_ready;

`ifdef PORTAS_LOGICAS_ACC_EN
   logic         s1_acc_q, s1_acc_d;
   logic [W-1:0] acc_q, acc_d;

   assign b_eff = s1_acc_q ? acc_q : s1_b_q;

   always_comb begin
      s1_acc_d = s1_acc_q;
      if (accept) s1_acc_d = acc;
   end

   // Clear beats the load; the advancing beat already used the old value.
   always_comb begin
      acc_d = acc_q;
      if (acc_clr)      acc_d = '0;
      else if (advance) acc_d = y_calc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_acc_q <= 1'b0;
         acc_q    <= '0;
      end else begin
         s1_acc_q <= s1_acc_d;
         acc_q    <= acc_d;
      end
   end
`else
   logic unused_acc_ports;

   assign unused_acc_ports = ^{acc, acc_clr};
   assign b_eff            = s1_b_q;
`endif

   always_comb begin
      y_calc = '0;
      case (s1_op_q)
         3'b000:  y_calc = s1_a_q & b_eff;
         3'b001:  y_calc = s1_a_q | b_eff;
         3'b010:  y_calc = ~(s1_a_q & b_eff);
         3'b011:  y_calc = ~(s1_a_q | b_eff);
         3'b100:  y_calc = s1_a_q ^ b_eff;
         3'b101:  y_calc = ~(s1_a_q ^ b_eff);
         3'b110:  y_calc = ~s1_a_q;
         default: y_calc = s1_a_q;
      endcase
   end

   always_comb begin
      s1_v_d  = s1_v_q;
      s1_a_d  = s1_a_q;
      s1_b_d  = s1_b_q;
      s1_op_d = s1_op_q;
      if (accept) begin
         s1_v_d  = 1'b1;
         s1_a_d  = a;
         s1_b_d  = b;
         s1_op_d = op;
      end else if (advance) begin
         s1_v_d  = 1'b0;
      end
   end

   always_comb begin
      s2_v_d = s2_v_q;
      y_d    = y_q;
      eq_d   = eq_q;
      zero_d = zero_q;
      if (advance) begin
         s2_v_d = 1'b1;
         y_d    = y_calc;
         eq_d   = (s1_a_q == b_eff);
         zero_d = (y_calc == '0);
      end else if (out_ready && s2_v_q) begin
         s2_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q  <= 1'b0;
         s1_a_q  <= '0;
         s1_b_q  <= '0;
         s1_op_q <= '0;
         s2_v_q  <= 1'b0;
         y_q     <= '0;
         eq_q    <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         s1_v_q  <= s1_v_d;
         s1_a_q  <= s1_a_d;
         s1_b_q  <= s1_b_d;
         s1_op_q <= s1_op_d;
         s2_v_q  <= s2_v_d;
         y_q     <= y_d;
         eq_q    <= eq_d;
         zero_q  <= zero_d;
      end
   end

   assign out_valid = s2_v_q;
   assign y         = y_q;
   assign eq        = eq_q;
   assign zero      = zero_q;

endmodule
